gs_mixer_mc: RTL and testbench

Parametrised multi-channel sample mixer for the General Sound path: replaces the fixed four-channel, fixed-routing multiply/add stage with a time-multiplexed multiply-accumulate engine. It supports N channels, per-channel stereo routing and saturating output. It sits between the GS CPU port/sample-latch logic and the board audio mixer. Per-channel sample, volume and pan registers are written from the GS side; a sample-rate strobe triggers one mix frame.

---
 rtl/gs_mixer_mc_if.sv | 43 ++++
 rtl/gs_mixer_mc.sv | 183 ++++++++++++++++++
 tb/tb_gs_mixer_mc.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gs_mixer_mc_if.sv
// gs_mixer_mc_if: control/status bundle for the gs_mixer_mc sample mixer.
//   Register writes: smp_we/smp_ch/smp_d, vol_we/vol_ch/vol_d, pan_we/pan_ch/pan_d
//   Frame control:   ce (engine clock enable), strobe (frame request), ovr_clr
//   Results:         out_l, out_r (signed mix), busy, done, overrun
// master drives the register/frame inputs; slave is the mixer.
interface gs_mixer_mc_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned VOL_W    = 6,
  parameter int unsigned OUT_W    = 15
);
  localparam int unsigned ChW = $clog2(CHANNELS);

  logic                ce;
  logic                strobe;
  logic                smp_we;
  logic [ChW-1:0]      smp_ch;
  logic [SAMPLE_W-1:0] smp_d;
  logic                vol_we;
  logic [ChW-1:0]      vol_ch;
  logic [VOL_W-1:0]    vol_d;
  logic                pan_we;
  logic [ChW-1:0]      pan_ch;
  logic [1:0]          pan_d;
  logic                ovr_clr;
  logic [OUT_W-1:0]    out_l;
  logic [OUT_W-1:0]    out_r;
  logic                busy;
  logic                done;
  logic                overrun;

  modport master (
    output ce, strobe, smp_we, smp_ch, smp_d, vol_we, vol_ch, vol_d,
           pan_we, pan_ch, pan_d, ovr_clr,
    input  out_l, out_r, busy, done, overrun
  );

  modport slave (
    input  ce, strobe, smp_we, smp_ch, smp_d, vol_we, vol_ch, vol_d,
           pan_we, pan_ch, pan_d, ovr_clr,
    output out_l, out_r, busy, done, overrun
  );
endinterface

// File: rtl/gs_mixer_mc.sv
// gs_mixer_mc: time-multiplexed multi-channel sample mixer for the General Sound path.
// Per-channel sample/volume/pan registers are written at any time; a strobe (qualified by ce)
// snapshots them and one multiply-accumulate per ce cycle builds the left and right sums,
// which are then reduced to OUT_W bits and registered.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - gs_mixer_mc_if.slave (register writes, ce/strobe, outputs and status)
// Build option: define GS_MIXER_SAT_EN to clamp the sums to the OUT_W signed range;
// otherwise the low OUT_W bits are kept (two's-complement wrap).
module gs_mixer_mc #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned VOL_W    = 6,
  parameter int unsigned OUT_W    = 15
) (
  input logic           clk,
  input logic           reset,
  gs_mixer_mc_if.slave  bus
);

  localparam int unsigned ChW = $clog2(CHANNELS);
  localparam int unsigned PW  = SAMPLE_W + VOL_W + 1;  // product width
  localparam int unsigned AW  = PW + ChW;              // accumulator width, cannot overflow
  localparam logic [ChW-1:0] LastIdx = ChW'(CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  // Live register file, written from the GS side.
  logic [SAMPLE_W-1:0] smp_q [CHANNELS];
  logic [VOL_W-1:0]    vol_q [CHANNELS];
  logic [1:0]          pan_q [CHANNELS];

  // Frame snapshot; the engine only ever reads these.
  logic [SAMPLE_W-1:0] smp_s_q [CHANNELS];
  logic [VOL_W-1:0]    vol_s_q [CHANNELS];
  logic [1:0]          pan_s_q [CHANNELS];

  state_e                state_q, state_d;
  logic [ChW-1:0]        idx_q, idx_d;
  logic signed [AW-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [OUT_W-1:0]      out_l_q, out_l_d, out_r_q, out_r_d;
  logic                  done_q, done_d;
  logic                  ovr_q, ovr_d;
  logic                  snap;

  always_ff @(posedge clk) begin : reg_file
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        smp_q[i] <= {1'b1, {(SAMPLE_W-1){1'b0}}};
        vol_q[i] <= '0;
        pan_q[i] <= (i < CHANNELS / 2) ? 2'b01 : 2'b10;
      end
    end else begin
      if (bus.smp_we) smp_q[bus.smp_ch] <= bus.smp_d;
      if (bus.vol_we) vol_q[bus.vol_ch] <= bus.vol_d;
      if (bus.pan_we) pan_q[bus.pan_ch] <= bus.pan_d;
    end
  end

  // Snapshot uses pre-edge register values, so a write on the strobe edge lands next frame.
  always_ff @(posedge clk) begin : shadow_regs
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        smp_s_q[i] <= '0;
        vol_s_q[i] <= '0;
        pan_s_q[i] <= '0;
      end
    end else if (snap) begin
      smp_s_q <= smp_q;
      vol_s_q <= vol_q;
      pan_s_q <= pan_q;
    end
  end

  // Offset-binary to two's complement is an MSB flip.
  logic [SAMPLE_W-1:0]  cur_smp;
  logic signed [PW-1:0] mul_a, mul_b, prod;
  logic signed [AW-1:0] prod_ext;

  always_comb begin
    cur_smp  = smp_s_q[idx_q];
    mul_a    = {{(PW-SAMPLE_W+1){~cur_smp[SAMPLE_W-1]}}, cur_smp[SAMPLE_W-2:0]};
    mul_b    = {{(PW-VOL_W){1'b0}}, vol_s_q[idx_q]};
    prod     = mul_a * mul_b;
    prod_ext = {{ChW{prod[PW-1]}}, prod};
  end

  logic [OUT_W-1:0] red_l, red_r;

  if (AW <= OUT_W) begin : g_ext
    assign red_l = OUT_W'(acc_l_q);
    assign red_r = OUT_W'(acc_r_q);
  end else begin : g_red
`ifdef GS_MIXER_SAT_EN
    localparam logic signed [AW-1:0] SatMax = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif
    function automatic logic [OUT_W-1:0] reduce(input logic signed [AW-1:0] a);
`ifdef GS_MIXER_SAT_EN
      if (a > SatMax)      reduce = SatMax[OUT_W-1:0];
      else if (a < SatMin) reduce = SatMin[OUT_W-1:0];
      else                 reduce = a[OUT_W-1:0];
`else
      reduce = a[OUT_W-1:0];
`endif
    endfunction
    assign red_l = reduce(acc_l_q);
    assign red_r = reduce(acc_r_q);
  end

  always_comb begin : next_state
    state_d = state_q;
    idx_d   = idx_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    snap    = 1'b0;

    // A lost strobe wins over a clear in the same cycle.
    if (bus.ovr_clr) ovr_d = 1'b0;
    if (bus.ce && bus.strobe && (state_q != StIdle)) ovr_d = 1'b1;

    if (bus.ce) begin
      unique case (state_q)
        StIdle: begin
          if (bus.strobe) begin
            snap    = 1'b1;
            acc_l_d = '0;
            acc_r_d = '0;
            idx_d   = '0;
            state_d = StAcc;
          end
        end
        StAcc: begin
          if (pan_s_q[idx_q][0]) acc_l_d = acc_l_q + prod_ext;
          if (pan_s_q[idx_q][1]) acc_r_d = acc_r_q + prod_ext;
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) state_d = StOut;
        end
        StOut: begin
          out_l_d = red_l;
          out_r_d = red_r;
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin : state_regs
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.out_l   = out_l_q;
  assign bus.out_r   = out_r_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_gs_mixer_mc.sv
// tb_gs_mixer_mc: self-checking bench for gs_mixer_mc (4 channels, 8-bit samples, 6-bit volume,
// 15-bit outputs). Table vectors, hand-written multi-cycle sequences and randomized frames
// checked against an arithmetic mix model.
module tb_gs_mixer_mc;
  localparam int unsigned Ch  = 4;
  localparam int unsigned SW  = 8;
  localparam int unsigned VW  = 6;
  localparam int unsigned OW  = 15;
  localparam int unsigned ChW = $clog2(Ch);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gs_mixer_mc_if #(.CHANNELS(Ch), .SAMPLE_W(SW), .VOL_W(VW), .OUT_W(OW)) bus ();

  gs_mixer_mc #(.CHANNELS(Ch), .SAMPLE_W(SW), .VOL_W(VW), .OUT_W(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model of the register file as written by the bench.
  int m_smp [Ch];
  int m_vol [Ch];
  int m_pan [Ch];

  typedef struct packed {
    logic [3:0][7:0] smp;
    logic [3:0][5:0] vol;
    logic [3:0][1:0] pan;
    int              exp_l;
    int              exp_r;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes;
    bus.smp_we = 1'b0;
    bus.vol_we = 1'b0;
    bus.pan_we = 1'b0;
  endtask

  task automatic model_defaults;
    for (int c = 0; c < Ch; c++) begin
      m_smp[c] = 128;
      m_vol[c] = 0;
      m_pan[c] = (c < Ch / 2) ? 1 : 2;
    end
  endtask

  // Clamp or wrap to the 15-bit signed output range.
  function automatic int reduce(input int s);
`ifdef GS_MIXER_SAT_EN
    if (s > 16383) return 16383;
    if (s < -16384) return -16384;
    return s;
`else
    int w;
    w = s & 32'h7FFF;
    if (w >= 16384) w = w - 32768;
    return w;
`endif
  endfunction

  task automatic model_mix(output int l, output int r);
    int sl = 0;
    int sr = 0;
    for (int c = 0; c < Ch; c++) begin
      int p;
      p = (m_smp[c] - 128) * m_vol[c];
      if (m_pan[c] % 2 == 1) sl += p;
      if (m_pan[c] >= 2) sr += p;
    end
    l = reduce(sl);
    r = reduce(sr);
  endtask

  task automatic write_ch(input int c, input int s, input int v, input int p);
    bus.smp_we = 1'b1; bus.smp_ch = ChW'(c); bus.smp_d = SW'(s);
    bus.vol_we = 1'b1; bus.vol_ch = ChW'(c); bus.vol_d = VW'(v);
    bus.pan_we = 1'b1; bus.pan_ch = ChW'(c); bus.pan_d = 2'(p);
    tick;
    clear_writes;
    m_smp[c] = s;
    m_vol[c] = v;
    m_pan[c] = p;
  endtask

  task automatic rand_write;
    int k;
    int c;
    clear_writes;
    k = $urandom_range(0, 3);
    c = $urandom_range(0, Ch - 1);
    case (k)
      0: begin
        m_smp[c] = $urandom_range(0, 255);
        bus.smp_we = 1'b1; bus.smp_ch = ChW'(c); bus.smp_d = SW'(m_smp[c]);
      end
      1: begin
        m_vol[c] = $urandom_range(0, 63);
        bus.vol_we = 1'b1; bus.vol_ch = ChW'(c); bus.vol_d = VW'(m_vol[c]);
      end
      2: begin
        m_pan[c] = $urandom_range(0, 3);
        bus.pan_we = 1'b1; bus.pan_ch = ChW'(c); bus.pan_d = 2'(m_pan[c]);
      end
      default: ;
    endcase
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    model_defaults();
  endtask

  // Runs after the strobe edge; counts ce edges up to and including the one that raises done.
  task automatic wait_done(input bit rnd, output int gl, output int gr, output int ce_edges);
    bit seen = 1'b0;
    bit ce_now;
    ce_edges = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (rnd) begin
        bus.ce = ($urandom_range(0, 3) != 0);
        rand_write();
      end else begin
        bus.ce = 1'b1;
      end
      ce_now = bus.ce;
      tick;
      if (ce_now) ce_edges++;
      seen = bus.done;
    end
    clear_writes;
    bus.ce = 1'b1;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done within 200 cycles");
    end
    gl = $signed(bus.out_l);
    gr = $signed(bus.out_r);
    check("busy_at_done", int'(bus.busy), 0);
  endtask

  task automatic run_frame(input bit rnd, output int gl, output int gr, output int ce_edges);
    clear_writes;
    bus.ce = 1'b1;
    bus.strobe = 1'b1;
    tick;
    bus.strobe = 1'b0;
    check("busy_rise", int'(bus.busy), 1);
    wait_done(rnd, gl, gr, ce_edges);
  endtask

  initial begin
    int gl, gr, ed, el, er, dn;

    bus.ce = 1'b1; bus.strobe = 1'b0; bus.ovr_clr = 1'b0;
    bus.smp_ch = '0; bus.smp_d = '0; bus.vol_ch = '0; bus.vol_d = '0;
    bus.pan_ch = '0; bus.pan_d = '0;
    clear_writes;

    vecs[0].smp = {8'h80, 8'hC0, 8'h00, 8'hFF};
    vecs[0].vol = {6'd0, 6'd10, 6'd32, 6'd63};
    vecs[0].pan = {2'b10, 2'b10, 2'b01, 2'b01};
    vecs[0].exp_l = 3905; vecs[0].exp_r = 640;
    vecs[1].smp = {4{8'hFF}};
    vecs[1].vol = {4{6'd63}};
    vecs[1].pan = {4{2'b01}};
    vecs[2].smp = {4{8'h00}};
    vecs[2].vol = {4{6'd63}};
    vecs[2].pan = {4{2'b01}};
`ifdef GS_MIXER_SAT_EN
    vecs[1].exp_l = 16383;
    vecs[2].exp_l = -16384;
`else
    vecs[1].exp_l = -764;
    vecs[2].exp_l = 512;
`endif
    vecs[1].exp_r = 0;
    vecs[2].exp_r = 0;
    vecs[3].smp = {8'h80, 8'h80, 8'h80, 8'h90};
    vecs[3].vol = {6'd0, 6'd0, 6'd0, 6'd4};
    vecs[3].pan = {2'b10, 2'b10, 2'b01, 2'b11};
    vecs[3].exp_l = 64; vecs[3].exp_r = 64;
    vecs[4] = vecs[3];
    vecs[4].pan = {2'b10, 2'b10, 2'b01, 2'b00};
    vecs[4].exp_l = 0; vecs[4].exp_r = 0;

    apply_reset();
    check("rst_out_l", int'(bus.out_l), 0);
    check("rst_out_r", int'(bus.out_r), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_overrun", int'(bus.overrun), 0);

    // Table vectors.
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < Ch; c++)
        write_ch(c, int'(vecs[i].smp[c]), int'(vecs[i].vol[c]), int'(vecs[i].pan[c]));
      run_frame(1'b0, gl, gr, ed);
      check($sformatf("vec%0d_l", i), gl, vecs[i].exp_l);
      check($sformatf("vec%0d_r", i), gr, vecs[i].exp_r);
      check($sformatf("vec%0d_latency", i), ed, Ch + 1);
      tick;
      check($sformatf("vec%0d_done_width", i), int'(bus.done), 0);
    end

    // Strobe while busy: overrun, clear, clear-vs-strobe priority, next accept at edge 6.
    apply_reset();
    dn = 0;
    bus.strobe = 1'b1; tick; bus.strobe = 1'b0;           // edge 0
    dn += int'(bus.done);
    tick;                                                  // edge 1
    dn += int'(bus.done);
    bus.strobe = 1'b1; tick; bus.strobe = 1'b0;           // edge 2
    dn += int'(bus.done);
    check("ovr_set", int'(bus.overrun), 1);
    bus.ovr_clr = 1'b1; tick; bus.ovr_clr = 1'b0;         // edge 3
    dn += int'(bus.done);
    check("ovr_clr", int'(bus.overrun), 0);
    bus.strobe = 1'b1; bus.ovr_clr = 1'b1; tick;          // edge 4
    bus.strobe = 1'b0; bus.ovr_clr = 1'b0;
    dn += int'(bus.done);
    check("ovr_strobe_beats_clr", int'(bus.overrun), 1);
    tick;                                                  // edge 5
    dn += int'(bus.done);
    check("ovr_busy_fall", int'(bus.busy), 0);
    bus.strobe = 1'b1; tick; bus.strobe = 1'b0;           // edge 6
    dn += int'(bus.done);
    check("ovr_done_count", dn, 1);
    check("ovr_accept_edge6", int'(bus.busy), 1);
    wait_done(1'b0, gl, gr, ed);
    check("ovr_second_latency", ed, Ch + 1);
    bus.ovr_clr = 1'b1; tick; bus.ovr_clr = 1'b0;

    // Volume write on the strobe edge lands in the next frame only.
    for (int c = 0; c < Ch; c++) write_ch(c, (c == 0) ? 255 : 128, (c == 0) ? 63 : 0, 1);
    model_mix(el, er);
    bus.vol_we = 1'b1; bus.vol_ch = '0; bus.vol_d = '0;
    bus.strobe = 1'b1;
    tick;
    bus.strobe = 1'b0;
    clear_writes;
    m_vol[0] = 0;
    wait_done(1'b0, gl, gr, ed);
    check("snap_old_l", gl, el);
    check("snap_old_val", gl, 8001);
    model_mix(el, er);
    run_frame(1'b0, gl, gr, ed);
    check("snap_new_l", gl, el);
    check("snap_new_r", gr, er);

    // Reset mid-frame aborts without done.
    write_ch(0, 255, 63, 1);
    run_frame(1'b0, gl, gr, ed);
    check("pre_abort_l", gl, 8001);
    bus.strobe = 1'b1; tick; bus.strobe = 1'b0;           // edge k
    tick;                                                  // edge k+1
    reset = 1'b1; tick; reset = 1'b0;                      // edge k+2
    model_defaults();
    check("abort_busy", int'(bus.busy), 0);
    check("abort_out_l", int'(bus.out_l), 0);
    check("abort_out_r", int'(bus.out_r), 0);
    dn = 0;
    for (int n = 0; n < 8; n++) begin
      tick;
      dn += int'(bus.done);
    end
    check("abort_no_done", dn, 0);
    run_frame(1'b0, gl, gr, ed);
    check("post_abort_l", gl, 0);
    check("post_abort_r", gr, 0);

    // Randomized frames with gappy ce and writes landing during busy.
    for (int f = 0; f < 40; f++) begin
      for (int c = 0; c < Ch; c++)
        write_ch(c, $urandom_range(0, 255), $urandom_range(0, 63), $urandom_range(0, 3));
      model_mix(el, er);
      run_frame(1'b1, gl, gr, ed);
      check($sformatf("rand%0d_l", f), gl, el);
      check($sformatf("rand%0d_r", f), gr, er);
      check($sformatf("rand%0d_latency", f), ed, Ch + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
